halfword_packer: RTL and testbench

//   Packs a stream of 16-bit halfwords into 32-bit words. It is the write-side

---
 rtl/halfword_packer.sv | 83 ++++++++
 tb/tb_halfword_packer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/halfword_packer.sv
// Packs a stream of 16-bit halfwords into 32-bit words. Both sides use valid/ready.
// A halfword flagged last flushes a partial word that is zero-padded on the unfilled side.
module halfword_packer #(
    parameter bit HI_FIRST = 1'b1,
    parameter int CNT_W    = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_bit0,
    output logic [15:0]      out_hi,
    output logic             out_partial,
    output logic             out_last,
    output logic [CNT_W-1:0] word_cnt
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_HALF  = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    logic [1:0]  state;
    logic [15:0] half;
    logic        in_xfer;
    logic        out_xfer;
    logic        open_slot;
    logic [31:0] padded;
    logic [31:0] joined;

    assign out_valid = (state == S_FULL);
    assign in_ready  = !reset && (state != S_FULL || out_ready);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;
    // A word leaving this cycle frees the slot, so the incoming half is handled as from empty.
    assign open_slot = (state == S_EMPTY) || out_xfer;

    assign padded = HI_FIRST ? {in_data, 16'h0} : {16'h0, in_data};
    assign joined = HI_FIRST ? {half, in_data}  : {in_data, half};

    assign out_bit0 = out_data[0];
    assign out_hi   = out_data[31:16];

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_EMPTY;
            half        <= 16'h0;
            out_data    <= 32'h0;
            out_partial <= 1'b0;
            out_last    <= 1'b0;
            word_cnt    <= '0;
        end else begin
            if (out_xfer)
                word_cnt <= word_cnt + CNT_W'(1);

            if (state == S_HALF) begin
                if (in_xfer) begin
                    out_data    <= joined;
                    out_partial <= 1'b0;
                    out_last    <= in_last;
                    state       <= S_FULL;
                end
            end else if (open_slot) begin
                if (in_xfer && in_last) begin
                    out_data    <= padded;
                    out_partial <= 1'b1;
                    out_last    <= 1'b1;
                    state       <= S_FULL;
                end else if (in_xfer) begin
                    half  <= in_data;
                    state <= S_HALF;
                end else begin
                    state <= S_EMPTY;
                end
            end
        end
    end

endmodule

// File: tb/tb_halfword_packer.sv
// Directed bench for halfword_packer; a HI_FIRST=0 instance shares the stimulus
// so both half orderings are checked against the same halfwords.
module tb_halfword_packer;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_ready;

    logic        in_ready, out_valid, out_bit0, out_partial, out_last;
    logic [31:0] out_data;
    logic [15:0] out_hi;
    logic [7:0]  word_cnt;

    logic        in_ready0, out_valid0, out_bit00, out_partial0, out_last0;
    logic [31:0] out_data0;
    logic [15:0] out_hi0;
    logic [7:0]  word_cnt0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    halfword_packer #(.HI_FIRST(1'b1), .CNT_W(8)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_bit0(out_bit0), .out_hi(out_hi), .out_partial(out_partial),
        .out_last(out_last), .word_cnt(word_cnt)
    );

    halfword_packer #(.HI_FIRST(1'b0), .CNT_W(8)) dut0 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .out_bit0(out_bit00), .out_hi(out_hi0), .out_partial(out_partial0),
        .out_last(out_last0), .word_cnt(word_cnt0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic l);
        in_valid = v;
        in_data  = d;
        in_last  = l;
    endtask

    int not_ready;

    initial begin
        reset = 1'b1; out_ready = 1'b0;
        drive(1'b0, 16'hxxxx, 1'b0);
        @(posedge clock); @(posedge clock);
        @(negedge clock);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_word_cnt", word_cnt, 0);
        check("rst_partial", out_partial, 0);
        reset = 1'b0;

        // Two halves, both orderings
        out_ready = 1'b1;
        drive(1'b1, 16'h8765, 1'b0);
        #1 check("t1_in_ready", in_ready, 1);
        @(negedge clock);
        check("t1_half_no_valid", out_valid, 0);
        drive(1'b1, 16'h4321, 1'b0);
        @(negedge clock);
        drive(1'b0, 16'hxxxx, 1'b0);
        check("t1_out_valid", out_valid, 1);
        check("t1_out_data", out_data, 32'h87654321);
        check("t1_out_bit0", out_bit0, 1);
        check("t1_out_hi", out_hi, 16'h8765);
        check("t1_partial", out_partial, 0);
        check("t2_out_data", out_data0, 32'h43218765);
        check("t2_out_bit0", out_bit00, 1);
        check("t2_out_hi", out_hi0, 16'h4321);
        @(negedge clock);
        check("t1_word_cnt", word_cnt, 1);
        check("t1_empty", out_valid, 0);
        check("t1_data_hold", out_data, 32'h87654321);

        // Flush of a single half
        drive(1'b1, 16'hABCD, 1'b1);
        @(negedge clock);
        out_ready = 1'b0;
        check("t3_out_data", out_data, 32'hABCD0000);
        check("t3_partial", out_partial, 1);
        check("t3_last", out_last, 1);
        check("t3_out_data_lo", out_data0, 32'h0000ABCD);

        // Backpressure with a halfword waiting
        drive(1'b1, 16'h1111, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t4_in_ready_low", in_ready, 0);
            check("t4_data_stable", out_data, 32'hABCD0000);
            check("t4_valid_held", out_valid, 1);
            @(negedge clock);
        end
        out_ready = 1'b1;
        #1 check("t4_in_ready_high", in_ready, 1);
        @(negedge clock);
        drive(1'b0, 16'hxxxx, 1'b0);
        check("t4_delivered_cnt", word_cnt, 2);
        check("t4_half_state", out_valid, 0);
        drive(1'b1, 16'h2222, 1'b1);
        @(negedge clock);
        drive(1'b0, 16'hxxxx, 1'b0);
        check("t4_joined", out_data, 32'h11112222);
        check("t4_joined_partial", out_partial, 0);
        check("t4_joined_last", out_last, 1);
        @(negedge clock);
        check("t4_cnt3", word_cnt, 3);

        // Reset with one half held
        drive(1'b1, 16'h5555, 1'b0);
        @(negedge clock);
        drive(1'b0, 16'hxxxx, 1'b0);
        reset = 1'b1;
        #1 check("t5_in_ready_rst", in_ready, 0);
        @(negedge clock);
        check("t5_cnt_rst", word_cnt, 0);
        check("t5_valid_rst", out_valid, 0);
        check("t5_data_rst", out_data, 0);
        reset = 1'b0;
        drive(1'b1, 16'h0001, 1'b0);
        @(negedge clock);
        drive(1'b1, 16'h0002, 1'b0);
        @(negedge clock);
        drive(1'b0, 16'hxxxx, 1'b0);
        check("t5_out_data", out_data, 32'h00010002);
        check("t5_cnt_before", word_cnt, 0);
        @(negedge clock);
        check("t5_cnt_after", word_cnt, 1);

        // 257 back-to-back words from a fresh count
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        not_ready = 0;
        for (int i = 0; i < 514; i++) begin
            drive(1'b1, 16'(i), 1'b0);
            #1 if (!in_ready) not_ready++;
            @(negedge clock);
        end
        drive(1'b0, 16'hxxxx, 1'b0);
        check("t6_not_ready", not_ready, 0);
        check("t6_last_word", out_data, 32'h02000201);
        check("t6_cnt_pre", word_cnt, 0);
        @(negedge clock);
        check("t6_cnt_wrap", word_cnt, 1);
        check("t6_empty", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
